// File: rtl/gpr_multiport.sv
// gpr_multiport: parametrised register file with byte-enabled writes, write-first bypass and a post-reset clear sweep
module gpr_multiport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wa,
   input  logic [DATA_W-1:0]          wd,
   input  logic [DATA_W/8-1:0]        wbe,
   input  logic [NUM_RD-1:0]          re,
   input  logic [NUM_RD*ADDR_W-1:0]   ra,
   output logic [NUM_RD*DATA_W-1:0]   rd,
   output logic                       init_busy
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mask, merged;
   logic [DATA_W-1:0] nxt [NUM_RD];
   logic              wr_ok;
   for (genvar b = 0; b < DATA_W/8; b++) begin : g_mask
      assign mask[8*b +: 8] = {8{wbe[b]}};
   end
   assign merged = (mem[wa] & ~mask) | (wd & mask);
   assign wr_ok  = we && !(ZERO_REG != 0 && wa == '0);
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign nxt[p] = (ZERO_REG != 0 && ra[p*ADDR_W +: ADDR_W] == '0) ? '0 :
                      (we && wa == ra[p*ADDR_W +: ADDR_W]) ? merged :
                      mem[ra[p*ADDR_W +: ADDR_W]];
   end
   // Storage has no reset so it maps onto block RAM; the sweep clears it instead.
   always_ff @(posedge clk) begin
      if (!rst && init_busy)
         mem[cnt] <= '0;
      else if (!rst && wr_ok)
         mem[wa] <= merged;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         init_busy <= 1'b1;
         cnt       <= '0;
         rd        <= '0;
      end else if (init_busy) begin
         cnt       <= cnt + 1'b1;
         init_busy <= ~&cnt;
         for (int p = 0; p < NUM_RD; p++)
            if (re[p]) rd[p*DATA_W +: DATA_W] <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++)
            if (re[p]) rd[p*DATA_W +: DATA_W] <= nxt[p];
      end
   end
endmodule

// File: tb/tb_gpr_multiport.sv
// tb_gpr_multiport: directed checks of sweep, writes, byte enables, bypass, zero register and read-enable hold
module tb_gpr_multiport;
   logic        clk = 0, rst = 1, we = 0, init_busy;
   logic [4:0]  wa = 0;
   logic [31:0] wd = 0;
   logic [3:0]  wbe = 0;
   logic [1:0]  re = 0;
   logic [9:0]  ra = 0;
   logic [63:0] rd;
   int          tests = 0, fails = 0;

   gpr_multiport dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
      .re(re), .ra(ra), .rd(rd), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1; wa = a; wd = d; wbe = be;
      step();
      we = 0;
   endtask

   task automatic sweep(input string tag);
      int n = 0;
      while (init_busy && n < 100) begin
         step();
         n++;
      end
      chk(tag, n, 32);
   endtask

   initial begin
      we = 1; wa = 5; wd = 32'hFFFFFFFF; wbe = 4'hF; re = 2'b11;
      step(3);
      chk("rst_rd0", rd[31:0], 0);
      chk("rst_rd1", rd[63:32], 0);
      chk("rst_busy", init_busy, 1);
      rst = 0;
      sweep("sweep_len");
      we = 0; ra = {5'd31, 5'd5};
      step();
      chk("sweep_e5", rd[31:0], 0);
      chk("sweep_e31", rd[63:32], 0);

      wr(7, 32'h12345678, 4'hF);
      ra = {5'd7, 5'd7}; re = 2'b11;
      step();
      chk("basic_p0", rd[31:0], 32'h12345678);
      chk("basic_p1", rd[63:32], 32'h12345678);

      re = 0;
      wr(3, 32'hAABBCCDD, 4'hF);
      ra = {5'd7, 5'd3}; re = 2'b01;
      wr(3, 32'h11223344, 4'b0101);
      chk("byp_p0", rd[31:0], 32'hAA22CC44);
      chk("byp_p1_hold", rd[63:32], 32'h12345678);
      ra = {5'd3, 5'd3}; re = 2'b11;
      wr(3, 32'h0, 4'h0);
      chk("nowbe_p0", rd[31:0], 32'hAA22CC44);
      chk("nowbe_p1", rd[63:32], 32'hAA22CC44);

      ra = {5'd0, 5'd0}; re = 2'b01;
      wr(0, 32'hDEADBEEF, 4'hF);
      chk("zero_byp", rd[31:0], 0);
      re = 2'b11;
      step();
      chk("zero_p0", rd[31:0], 0);
      chk("zero_p1", rd[63:32], 0);

      re = 0;
      wr(2, 32'h55, 4'hF);
      ra = {5'd2, 5'd0}; re = 2'b10;
      step();
      chk("hold_init", rd[63:32], 32'h55);
      re = 0; ra = {5'd7, 5'd0};
      wr(2, 32'h66, 4'hF);
      chk("hold_c0", rd[63:32], 32'h55);
      for (int i = 1; i < 4; i++) begin
         ra = {5'(i + 8), 5'd0};
         step();
         chk($sformatf("hold_c%0d", i), rd[63:32], 32'h55);
      end
      ra = {5'd2, 5'd0}; re = 2'b10;
      step();
      chk("hold_new", rd[63:32], 32'h66);

      re = 0;
      rst = 1;
      step();
      chk("mrst_rd0", rd[31:0], 0);
      chk("mrst_rd1", rd[63:32], 0);
      chk("mrst_busy", init_busy, 1);
      rst = 0;
      we = 1; wa = 9; wd = 32'hCAFEF00D; wbe = 4'hF;
      step(10);
      chk("mid_busy", init_busy, 1);
      rst = 1;
      step();
      rst = 0;
      sweep("sweep_restart");
      we = 0; ra = {5'd2, 5'd7}; re = 2'b11;
      step();
      chk("clr_e7", rd[31:0], 0);
      chk("clr_e2", rd[63:32], 0);
      ra = {5'd9, 5'd3};
      step();
      chk("clr_e3", rd[31:0], 0);
      chk("clr_e9", rd[63:32], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/gpr_multiport.md
# gpr_multiport

Parametrised general-purpose register file, successor to the fixed 32x32 two-read-port GPR in the MIPS CPU datapath. It provides configurable data width, depth and read-port count, plus byte-enabled writes, a hardwired zero register, write-to-read bypass and per-port read-enable (stall hold). A post-reset clear sweep zeroes the array one entry per cycle, which keeps the storage inferable as block RAM. The decode/operand-fetch stage instantiates it, and writeback drives the write port.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores writes.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; starts the clear sweep.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit i covers wd[8i+7:8i].
- re  in  NUM_RD  per-port read enable.
- ra  in  NUM_RD*ADDR_W  read addresses; port p occupies [p*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  registered read data; port p occupies [p*DATA_W +: DATA_W].
- init_busy  out  1  high while the clear sweep runs.

## Operation
- Reset, sampled high at an edge, has these effects:
  - all rd are set to 0;
  - init_busy is set to 1;
  - the sweep counter is set to 0.
- rst held high keeps the counter at 0.
- Clear sweep:
  - Each cycle with init_busy=1 and rst=0 writes 0 to entry[counter] and increments the counter.
  - When counter == DEPTH-1 is written, init_busy falls at that edge.
  - The sweep therefore takes DEPTH cycles after rst deasserts.
- During the sweep:
  - we is ignored; no user write occurs.
  - Every rd updates to 0 where re=1 and holds where re=0.
- Write (init_busy=0):
  - When we=1, bytes of entry[wa] with wbe[i]=1 take wd; other bytes keep their value.
  - we=1 with wbe=0 is a no-op.
  - If ZERO_REG=1 and wa=0, the write is dropped.
- Read (init_busy=0), per port p:
  - re[p]=1: rd_p at the next edge = merged value of entry[ra_p].
  - re[p]=0: rd_p holds.
- Bypass, write-first:
  - Applies when we=1, wa==ra_p and re[p]=1 in the same cycle.
  - rd_p gets the entry with the enabled new bytes merged in, i.e. the post-write value.
  - Unwritten bytes come from the old entry.
- Zero register: if ZERO_REG=1 and ra_p=0, rd_p updates to 0 regardless of bypass.
- Ports are independent. All ports may read the same address, including the write address, in the same cycle.
- Reset mid-sweep or mid-operation restarts the sweep from entry 0. Array contents are not otherwise relied on.

## Timing
- Read latency: 1 cycle. Address and re are presented at edge N; data is valid after edge N and until the next enabled read.
- Write-to-read latency:
  - 0 cycles through bypass, same-cycle read.
  - From edge N+1 onward, reads return the array value.
- Reset values: rd = 0, init_busy = 1.
- init_busy is 1 for exactly DEPTH cycles after the first edge with rst=0. The first user write is accepted on edge DEPTH+1 after reset deasserts.
- There are no combinational paths from inputs to outputs. All outputs are registers.

## Test plan
- Reset/sweep:
  - Stimulus: DEPTH=32; hold rst 3 cycles, release; drive we=1, wa=5, wd=0xFFFFFFFF, wbe=0xF throughout.
  - Response: init_busy stays high exactly 32 cycles. After it falls, reading entry 5 returns 0. Reading entry 31 returns 0.
- Basic write/read:
  - Stimulus: write 0x12345678 to entry 7 with wbe=0xF; next cycle, port0 ra=7 and port1 ra=7, both re=1.
  - Response: both rd show 0x12345678 one cycle later.
- Byte enables and bypass:
  - Stimulus: entry 3 holds 0xAABBCCDD; in one cycle write wd=0x11223344, wbe=0b0101, wa=3 while port0 reads ra=3.
  - Response: rd0 = 0xAA22CC44 after that edge. The array holds 0xAA22CC44.
- Zero register:
  - Stimulus: ZERO_REG=1; write 0xDEADBEEF to entry 0 with a concurrent read of 0.
  - Response: rd = 0 that cycle and on every later read of entry 0.
- Read enable hold:
  - Stimulus: port1 reads entry 2 (=0x55); then re[1]=0 for 4 cycles while ra changes and entry 2 is rewritten to 0x66.
  - Response: rd1 stays 0x55 for all 4 cycles. The next enabled read returns 0x66.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle 10 cycles into the sweep, and again after user writes have been made.
  - Response: rd = 0 after the reset edge. init_busy is high for a full DEPTH cycles again. All prior contents read 0 afterwards.
